// File: rtl/cnt_mon_pkg.sv
// Shared definitions for the count monitor: mode encodings, FSM states,
// step classes and the state-to-mode mapping.
// Purely declarative; no logic, no latency, no flow control.
package cnt_mon_pkg;

  // Mode encodings, identical to the counter's ctrl field
  localparam logic [2:0] MODE_UP   = 3'd0;
  localparam logic [2:0] MODE_DOWN = 3'd1;
  localparam logic [2:0] MODE_UPDN = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_HOLD = 3'd4;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_UP,
    ST_DOWN,
    ST_BOUNCE,
    ST_HOLD,
    ST_LOAD
  } state_t;

  // Relationship between two consecutive legal samples
  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DN,
    STEP_JUMP
  } step_t;

  // EMPTY has no mode of its own and reports as hold
  function automatic logic [2:0] mode_of(input state_t s);
    case (s)
      ST_UP:     return MODE_UP;
      ST_DOWN:   return MODE_DOWN;
      ST_BOUNCE: return MODE_UPDN;
      ST_LOAD:   return MODE_LOAD;
      default:   return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/count_monitor_therm_decode.sv
// Thermometer-to-binary decoder with legality check against modulus N.
// Latency: combinational. No flow control.
// Ports: code (16-bit thermometer in), value (4-bit binary), legal (code is
// 2^k-1 with k<=15 and k<N).
module therm_decode #(
  parameter int N = 10
) (
  input  logic [15:0] code,
  output logic [3:0]  value,
  output logic        legal
);

  logic hit;

  // Exact match against every well-formed pattern; 0xFFFF (k=16) has no
  // 4-bit representation and never matches.
  always_comb begin
    value = 4'd0;
    hit   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (code == 16'((32'd1 << k) - 32'd1)) begin
        value = 4'(k);
        hit   = 1'b1;
      end
    end
  end

  assign legal = hit && (int'(value) < N);

endmodule

// File: rtl/count_monitor.sv
// Decodes the mod-N counter's thermometer stream, flags bad codes and infers
// the counter's running mode from consecutive samples.
// Latency: 1 cycle, outputs reflect the sample accepted on the previous edge.
// Backpressure: none; a sample is consumed whenever valid_in is high.
// Ports: clk, rst (sync active-high), valid_in/t_count_in (sample in),
// count_out, code_err, err_count, mode_out, mode_valid, wrap_pulse, turn_pulse.
module count_monitor
  import cnt_mon_pkg::*;
#(
  parameter int N       = 10,
  parameter int CONFIRM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] t_count_in,
  output logic [3:0]  count_out,
  output logic        code_err,
  output logic [7:0]  err_count,
  output logic [2:0]  mode_out,
  output logic        mode_valid,
  output logic        wrap_pulse,
  output logic        turn_pulse
);

  localparam logic [3:0] NM1      = 4'(N - 1);
  localparam logic [3:0] CONF_THR = 4'(CONFIRM);

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] conf_q, conf_d;
  logic [7:0] ec_q, ec_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;
  logic       turn_q, turn_d;

  logic [3:0] dec_val;
  logic       dec_legal;
  step_t      step;
  logic       wrap_up, wrap_dn, is_wrap;

  therm_decode #(.N(N)) u_dec (
    .code  (t_count_in),
    .value (dec_val),
    .legal (dec_legal)
  );

  // Step classification. The +1 compares are done 5 bits wide so prev=15
  // (N=16) cannot alias onto 0; wraps are caught by explicit boundary tests.
  always_comb begin
    wrap_up = (prev_q == NM1) && (dec_val == 4'd0);
    wrap_dn = (prev_q == 4'd0) && (dec_val == NM1);
    step    = STEP_JUMP;
    if (dec_val == prev_q)
      step = STEP_HOLD;
    else if (({1'b0, dec_val} == {1'b0, prev_q} + 5'd1) || wrap_up)
      step = STEP_UP;
    else if (({1'b0, dec_val} + 5'd1 == {1'b0, prev_q}) || wrap_dn)
      step = STEP_DN;
    is_wrap = ((step == STEP_UP) && wrap_up) || ((step == STEP_DN) && wrap_dn);
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    conf_d  = conf_q;
    ec_d    = ec_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    turn_d  = 1'b0;

    if (valid_in) begin
      if (!dec_legal) begin
        // Bad codes touch nothing but the error outputs
        err_d = 1'b1;
        if (ec_q != 8'hFF)
          ec_d = ec_q + 8'd1;
      end else if (state_q == ST_EMPTY) begin
        // First sample only seeds the history
        prev_d  = dec_val;
        state_d = ST_HOLD;
        conf_d  = 4'd0;
      end else begin
        prev_d = dec_val;
        wrap_d = is_wrap;
        case (step)
          STEP_HOLD: state_d = ST_HOLD;
          STEP_UP: begin
            if ((state_q == ST_DOWN || state_q == ST_BOUNCE) &&
                prev_q == 4'd0 && !is_wrap) begin
              state_d = ST_BOUNCE;
              turn_d  = 1'b1;
            end else if (state_q == ST_BOUNCE && !is_wrap) begin
              state_d = ST_BOUNCE;
            end else begin
              state_d = ST_UP;
            end
          end
          STEP_DN: begin
            if ((state_q == ST_UP || state_q == ST_BOUNCE) &&
                prev_q == NM1 && !is_wrap) begin
              state_d = ST_BOUNCE;
              turn_d  = 1'b1;
            end else if (state_q == ST_BOUNCE && !is_wrap) begin
              state_d = ST_BOUNCE;
            end else begin
              state_d = ST_DOWN;
            end
          end
          default: state_d = ST_LOAD;
        endcase

        if (state_d == state_q)
          conf_d = (conf_q == 4'd15) ? conf_q : conf_q + 4'd1;
        else
          conf_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      prev_q  <= 4'd0;
      conf_q  <= 4'd0;
      ec_q    <= 8'd0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      conf_q  <= conf_d;
      ec_q    <= ec_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      turn_q  <= turn_d;
    end
  end

  // The last legal sample is both the step history and the reported value
  assign count_out  = prev_q;
  assign code_err   = err_q;
  assign err_count  = ec_q;
  assign mode_out   = mode_of(state_q);
  assign mode_valid = (conf_q >= CONF_THR);
  assign wrap_pulse = wrap_q;
  assign turn_pulse = turn_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed test of count_monitor with N=10, CONFIRM=2.
// Each sample is applied on a falling edge and checked 1 time unit after the
// following rising edge, against hand-computed expectations.
module tb_count_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] t_count_in;
  logic [3:0]  count_out;
  logic        code_err;
  logic [7:0]  err_count;
  logic [2:0]  mode_out;
  logic        mode_valid;
  logic        wrap_pulse;
  logic        turn_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int step_id = 0;

  count_monitor #(.N(10), .CONFIRM(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .t_count_in (t_count_in),
    .count_out  (count_out),
    .code_err   (code_err),
    .err_count  (err_count),
    .mode_out   (mode_out),
    .mode_valid (mode_valid),
    .wrap_pulse (wrap_pulse),
    .turn_pulse (turn_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] th(input int k);
    return 16'((32'd1 << k) - 32'd1);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input int cnt, input int err, input int ec,
                            input int mode, input int mv, input int wr, input int tn);
    string t;
    t = $sformatf("v%0d", step_id);
    chk({t, ".count_out"},  16'(count_out),  16'(cnt));
    chk({t, ".code_err"},   16'(code_err),   16'(err));
    chk({t, ".err_count"},  16'(err_count),  16'(ec));
    chk({t, ".mode_out"},   16'(mode_out),   16'(mode));
    chk({t, ".mode_valid"}, 16'(mode_valid), 16'(mv));
    chk({t, ".wrap_pulse"}, 16'(wrap_pulse), 16'(wr));
    chk({t, ".turn_pulse"}, 16'(turn_pulse), 16'(tn));
    step_id++;
  endtask

  task automatic samp(input logic [15:0] code);
    @(negedge clk);
    valid_in   = 1'b1;
    t_count_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [15:0] code, input int cnt, input int err, input int ec,
                    input int mode, input int mv, input int wr, input int tn);
    samp(code);
    expect_all(cnt, err, ec, mode, mv, wr, tn);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    t_count_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    expect_all(0, 0, 0, 4, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Up count: seed, then two UP steps confirm
    st(th(0), 0, 0, 0, 4, 0, 0, 0);
    st(th(1), 1, 0, 0, 0, 0, 0, 0);
    st(th(2), 2, 0, 0, 0, 1, 0, 0);
    st(th(3), 3, 0, 0, 0, 1, 0, 0);
    idle();
    expect_all(3, 0, 0, 0, 1, 0, 0);
    for (int k = 4; k <= 9; k++) st(th(k), k, 0, 0, 0, 1, 0, 0);
    // 9 -> 0 wraps
    st(th(0), 0, 0, 0, 0, 1, 1, 0);
    st(th(1), 1, 0, 0, 0, 1, 0, 0);
    for (int k = 2; k <= 9; k++) st(th(k), k, 0, 0, 0, 1, 0, 0);

    // Bounce off the top, down to 0, bounce off the bottom
    st(th(8), 8, 0, 0, 2, 0, 0, 1);
    for (int k = 7; k >= 0; k--) st(th(k), k, 0, 0, 2, 1, 0, 0);
    st(th(1), 1, 0, 0, 2, 1, 0, 1);

    // Malformed, k=16, and k>=N codes
    st(16'h0005, 1, 1, 1, 2, 1, 0, 0);
    st(16'hFFFF, 1, 1, 2, 2, 1, 0, 0);
    st(16'h0FFF, 1, 1, 3, 2, 1, 0, 0);
    idle();
    expect_all(1, 0, 3, 2, 1, 0, 0);
    // prev must still be 1: 1->2 is a non-turning bounce step
    st(th(2), 2, 0, 3, 2, 1, 0, 0);

    // Hold, load, hold
    st(th(3), 3, 0, 3, 2, 1, 0, 0);
    st(th(3), 3, 0, 3, 4, 0, 0, 0);
    st(th(3), 3, 0, 3, 4, 1, 0, 0);
    st(th(7), 7, 0, 3, 3, 0, 0, 0);
    st(th(7), 7, 0, 3, 4, 0, 0, 0);
    st(th(7), 7, 0, 3, 4, 1, 0, 0);

    // Down count with 0 -> 9 wrap
    st(th(6), 6, 0, 3, 1, 0, 0, 0);
    for (int k = 5; k >= 0; k--) st(th(k), k, 0, 3, 1, 1, 0, 0);
    st(th(9), 9, 0, 3, 1, 1, 1, 0);

    // k == N is out of range
    st(th(10), 9, 1, 4, 1, 1, 0, 0);

    // Error counter saturation
    for (int i = 0; i < 251; i++) samp(16'h0005);
    st(16'h0005, 9, 1, 255, 1, 1, 0, 0);
    st(th(8), 8, 0, 255, 1, 1, 0, 0);

    // Reset mid-stream wins over a valid sample
    @(negedge clk);
    rst        = 1'b1;
    valid_in   = 1'b1;
    t_count_in = th(3);
    @(posedge clk);
    #1;
    expect_all(0, 0, 0, 4, 0, 0, 0);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    st(th(5), 5, 0, 0, 4, 0, 0, 0);
    st(th(6), 6, 0, 0, 0, 0, 0, 0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
